// File: rtl/ram_load_arbiter.sv
// Shared single-port RAM arbiter: the core has priority, loader writes are buffered
// in a FIFO, and a starvation counter forces a loader slot after STARVE_LIMIT core grants.
module ram_load_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 16,
  parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        core_cs,
  input  logic        core_we,
  input  logic [15:0] core_ad,
  input  logic [7:0]  core_d,
  output logic [7:0]  core_q,
  output logic        core_wait,
  input  logic        ld_wr,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_d,
  output logic        ld_wait,
  output logic        ld_busy,
  output logic [15:0] mem_ad,
  output logic [7:0]  mem_d,
  output logic        mem_we,
  input  logic [7:0]  mem_q
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, CORE = 2'd1, LOAD = 2'd2} arb_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } ld_entry_t;

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             we_q, we_d;
  logic [7:0]       core_q_q;
  logic             push, pop, fifo_nempty, fifo_full;
  ld_entry_t        fifo_mem [FIFO_DEPTH];
  ld_entry_t        head;

  assign head = fifo_mem[rd_ptr_q];

  // Grant decision, RAM mux, FIFO bookkeeping and starvation counter.
  always_comb begin
    state_d     = IDLE;
    starve_d    = '0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    we_d        = 1'b1;
    pop         = 1'b0;
    push        = 1'b0;
    mem_ad      = '0;
    mem_d       = '0;
    mem_we      = 1'b0;
    core_wait   = 1'b0;
    fifo_nempty = (cnt_q != '0);
    fifo_full   = (cnt_q == CNT_W'(FIFO_DEPTH));
    ld_wait     = fifo_full;
    ld_busy     = fifo_nempty;
    // Read data is live only in the cycle after a core read grant.
    core_q      = (state_q == CORE && !we_q) ? mem_q : core_q_q;

    // Reset gating keeps the RAM port quiet while reset_n is low.
    if (reset_n) begin
      if (core_cs && !(starve_q == STV_W'(STARVE_LIMIT) && fifo_nempty)) begin
        state_d = CORE;
      end else if (fifo_nempty) begin
        state_d = LOAD;
      end
    end

    case (state_d)
      CORE: begin
        mem_ad = core_ad;
        mem_d  = core_d;
        mem_we = core_we;
        we_d   = core_we;
        if (fifo_nempty) begin
          starve_d = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q : starve_q + STV_W'(1);
        end
      end
      LOAD: begin
        mem_ad    = head.addr;
        mem_d     = head.data;
        mem_we    = 1'b1;
        pop       = 1'b1;
        core_wait = core_cs;
      end
      default: ;
    endcase

    // A pop frees the head slot in the same cycle, so a push is accepted even at full.
    push = ld_wr && (!fifo_full || pop);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      we_q     <= 1'b1;
      core_q_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      core_q_q <= core_q;
    end
  end

  // FIFO storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{addr: ld_addr + BASE_ADDR, data: ld_d};
    end
  end

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Directed bench for ram_load_arbiter: behavioural synchronous RAM plus hand-computed
// expectations for core access, loader bursts, starvation, wrap and reset.
module tb_ram_load_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_cs = 1'b0, core_we = 1'b0;
  logic [15:0] core_ad = '0;
  logic [7:0]  core_d = '0, core_q;
  logic        core_wait;
  logic        ld_wr = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [7:0]  ld_d = '0;
  logic        ld_wait, ld_busy;
  logic [15:0] mem_ad;
  logic [7:0]  mem_d, mem_q;
  logic        mem_we;

  logic        w_ld_wr = 1'b0;
  logic [15:0] w_ld_addr = '0;
  logic [7:0]  w_ld_d = '0, w_core_q, w_mem_d;
  logic        w_core_wait, w_ld_wait, w_ld_busy, w_mem_we;
  logic [15:0] w_mem_ad;

  logic [7:0]  ram [65536];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk_sys = ~clk_sys;

  ram_load_arbiter u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .core_cs(core_cs), .core_we(core_we), .core_ad(core_ad), .core_d(core_d),
    .core_q(core_q), .core_wait(core_wait),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_d(ld_d), .ld_wait(ld_wait), .ld_busy(ld_busy),
    .mem_ad(mem_ad), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
  );

  ram_load_arbiter #(.BASE_ADDR(16'hFFFE)) u_wrap (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .core_cs(1'b0), .core_we(1'b0), .core_ad(16'h0000), .core_d(8'h00),
    .core_q(w_core_q), .core_wait(w_core_wait),
    .ld_wr(w_ld_wr), .ld_addr(w_ld_addr), .ld_d(w_ld_d), .ld_wait(w_ld_wait), .ld_busy(w_ld_busy),
    .mem_ad(w_mem_ad), .mem_d(w_mem_d), .mem_we(w_mem_we), .mem_q(8'h00)
  );

  // Synchronous RAM: read data appears one cycle after the address.
  always @(posedge clk_sys) begin
    if (mem_we) ram[mem_ad] <= mem_d;
    mem_q <= ram[mem_ad];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          grants;
    logic [15:0] exp_ad [4];
    logic [7:0]  exp_d  [4];

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1234] = 8'hA5;
    ram[16'h3000] = 8'h3C;

    // Reset holds outputs low even with a live core request.
    core_cs = 1'b1; core_we = 1'b1; core_ad = 16'hBEEF; core_d = 8'h11;
    #3;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_ad", 32'(mem_ad), 32'h0);
    check("rst_core_wait", 32'(core_wait), 32'd0);
    check("rst_ld_wait", 32'(ld_wait), 32'd0);
    check("rst_ld_busy", 32'(ld_busy), 32'd0);
    check("rst_core_q", 32'(core_q), 32'h00);
    core_cs = 1'b0; core_we = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;

    // Core read of 0x1234.
    next_cyc();
    core_cs = 1'b1; core_we = 1'b0; core_ad = 16'h1234;
    @(negedge clk_sys);
    check("rd_mem_ad", 32'(mem_ad), 32'h1234);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    check("rd_core_wait", 32'(core_wait), 32'd0);
    next_cyc();
    core_cs = 1'b0; core_ad = 16'h0000;
    @(negedge clk_sys);
    check("rd_core_q", 32'(core_q), 32'hA5);
    check("idle_mem_we", 32'(mem_we), 32'd0);

    // Core write must not disturb core_q; read it back afterwards.
    next_cyc();
    core_cs = 1'b1; core_we = 1'b1; core_ad = 16'h2000; core_d = 8'h5C;
    @(negedge clk_sys);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_d", 32'(mem_d), 32'h5C);
    next_cyc();
    core_we = 1'b0;
    @(negedge clk_sys);
    check("wr_core_q_hold", 32'(core_q), 32'hA5);
    next_cyc();
    core_cs = 1'b0;
    @(negedge clk_sys);
    check("wr_readback", 32'(core_q), 32'h5C);

    // Loader burst with the core idle: drained one entry per cycle.
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      ld_wr   = (i < 4);
      ld_addr = 16'h0500 + 16'(i);
      ld_d    = 8'h10 + 8'(i);
      @(negedge clk_sys);
      if (i >= 1 && i <= 4) begin
        check("burst_we", 32'(mem_we), 32'd1);
        check("burst_ad", 32'(mem_ad), 32'h0500 + 32'(i - 1));
        check("burst_d", 32'(mem_d), 32'h10 + 32'(i - 1));
        check("burst_ld_wait", 32'(ld_wait), 32'd0);
        check("burst_busy", 32'(ld_busy), 32'd1);
      end else if (i == 5) begin
        check("burst_busy_fall", 32'(ld_busy), 32'd0);
        check("burst_idle_we", 32'(mem_we), 32'd0);
      end
    end

    // Core hogs the RAM while the loader fills the FIFO; starvation slot at the limit.
    grants = 0;
    for (int c = 0; c < 18; c++) begin
      next_cyc();
      core_cs = 1'b1; core_we = 1'b0; core_ad = 16'h3000;
      ld_wr   = (c < 6) || (c == 17);
      ld_addr = (c == 17) ? 16'h0700 : 16'h0600 + 16'(c);
      ld_d    = (c == 17) ? 8'h77 : 8'h20 + 8'(c);
      @(negedge clk_sys);
      if (c == 3) check("fill_ld_wait3", 32'(ld_wait), 32'd0);
      if (c == 4) check("fill_ld_wait4", 32'(ld_wait), 32'd1);
      if (c >= 1 && c <= 16 && mem_ad == 16'h3000 && !mem_we && !core_wait && ld_busy) grants++;
      if (c == 17) begin
        check("starve_we", 32'(mem_we), 32'd1);
        check("starve_ad", 32'(mem_ad), 32'h0600);
        check("starve_d", 32'(mem_d), 32'h20);
        check("starve_core_wait", 32'(core_wait), 32'd1);
        check("starve_core_q", 32'(core_q), 32'h3C);
      end
    end
    check("starve_grants", 32'(grants), 32'd16);
    next_cyc();
    ld_wr = 1'b0;
    @(negedge clk_sys);
    check("full_pushpop_wait", 32'(ld_wait), 32'd1);
    check("post_slot_core_wait", 32'(core_wait), 32'd0);
    check("post_slot_ad", 32'(mem_ad), 32'h3000);
    check("post_slot_core_q", 32'(core_q), 32'h3C);

    exp_ad = '{16'h0601, 16'h0602, 16'h0603, 16'h0700};
    exp_d  = '{8'h21, 8'h22, 8'h23, 8'h77};
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      core_cs = 1'b0;
      @(negedge clk_sys);
      if (i < 4) begin
        check("drain_we", 32'(mem_we), 32'd1);
        check("drain_ad", 32'(mem_ad), 32'(exp_ad[i]));
        check("drain_d", 32'(mem_d), 32'(exp_d[i]));
      end else begin
        check("drain_busy", 32'(ld_busy), 32'd0);
      end
    end

    // Address offset wraps modulo 2^16.
    next_cyc();
    w_ld_wr = 1'b1; w_ld_addr = 16'h0003; w_ld_d = 8'h99;
    next_cyc();
    w_ld_wr = 1'b0;
    @(negedge clk_sys);
    check("wrap_ad", 32'(w_mem_ad), 32'h0001);
    check("wrap_we", 32'(w_mem_we), 32'd1);
    check("wrap_d", 32'(w_mem_d), 32'h99);

    // Reset with three entries pending.
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      core_cs = 1'b1; core_we = 1'b0; core_ad = 16'h3000;
      ld_wr   = (i < 3);
      ld_addr = 16'h0800 + 16'(i);
      ld_d    = 8'h40 + 8'(i);
    end
    @(negedge clk_sys);
    check("pend_busy", 32'(ld_busy), 32'd1);
    check("pend_core_q", 32'(core_q), 32'h3C);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(ld_busy), 32'd0);
    check("arst_core_q", 32'(core_q), 32'h00);
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_core_wait", 32'(core_wait), 32'd0);
    check("arst_ld_wait", 32'(ld_wait), 32'd0);
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    core_cs = 1'b1; core_ad = 16'h1234;
    @(negedge clk_sys);
    check("first_grant_ad", 32'(mem_ad), 32'h1234);
    check("first_grant_wait", 32'(core_wait), 32'd0);
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      core_cs = 1'b0;
      @(negedge clk_sys);
      if (i == 0) check("first_grant_q", 32'(core_q), 32'hA5);
      check("post_rst_we", 32'(mem_we), 32'd0);
      check("post_rst_busy", 32'(ld_busy), 32'd0);
    end

    // Final RAM image.
    for (int i = 0; i < 4; i++) begin
      check("ram_burst", 32'(ram[16'h0500 + 16'(i)]), 32'h10 + 32'(i));
      check("ram_fill", 32'(ram[16'h0600 + 16'(i)]), 32'h20 + 32'(i));
    end
    check("ram_ignored4", 32'(ram[16'h0604]), 32'h00);
    check("ram_ignored5", 32'(ram[16'h0605]), 32'h00);
    check("ram_pushpop", 32'(ram[16'h0700]), 32'h77);
    for (int i = 0; i < 3; i++) check("ram_discarded", 32'(ram[16'h0800 + 16'(i)]), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
